// File: rtl/kyber_pkg.sv
// Shared Kyber constants and coefficient types for the Montgomery reduction datapath.
// Build option MONT_REDUCE_PIPE_CANON_EN adds a fourth, canonicalising pipeline stage.
package kyber_pkg;

  localparam int KYBER_W    = 16;
  localparam int KYBER_Q    = 3329;
  localparam int KYBER_QINV = -3327;
  localparam int KYBER_MONT = -1044;

  typedef logic signed [KYBER_W-1:0]   coef_t;
  typedef logic signed [2*KYBER_W-1:0] prod_t;

`ifdef MONT_REDUCE_PIPE_CANON_EN
  localparam int MONT_STAGES = 4;
`else
  localparam int MONT_STAGES = 3;
`endif

endpackage

// File: rtl/mont_reduce_lane.sv
// One lane of signed Montgomery reduction: r = (a - (a*QINV mod 2^W)*Q) >>> W.
// Macro MONT_REDUCE_PIPE_CANON_EN appends a stage mapping r into [0, Q).
module mont_reduce_lane
  import kyber_pkg::*;
#(
  parameter int WIDTH = KYBER_W,
  parameter int Q     = KYBER_Q,
  parameter int QINV  = KYBER_QINV
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2*WIDTH-1:0]   in_a,
  output logic [WIDTH-1:0]     out_r
);

  localparam logic [WIDTH-1:0]          QINV_W = WIDTH'(QINV);
  localparam logic signed [2*WIDTH-1:0] Q_P    = (2*WIDTH)'(Q);

  logic signed [2*WIDTH-1:0] r_a1, r_a2, r_p2;
  logic signed [WIDTH-1:0]   r_t1, r_r3;
  logic [WIDTH-1:0]          w_t;
  logic signed [2*WIDTH-1:0] w_t_ext, w_p;
  logic signed [WIDTH-1:0]   w_r;

  // The low W bits of a - p are zero by construction, so the upper half is the result.
  always_comb begin
    w_t     = in_a[WIDTH-1:0] * QINV_W;
    w_t_ext = {{WIDTH{r_t1[WIDTH-1]}}, r_t1};
    w_p     = w_t_ext * Q_P;
    w_r     = WIDTH'((r_a2 - r_p2) >>> WIDTH);
  end

  // NOTE: datapath registers are reset too, so out_data reads zero (not stale data) after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a1 <= '0;
      r_t1 <= '0;
      r_a2 <= '0;
      r_p2 <= '0;
      r_r3 <= '0;
    end else if (en) begin
      r_a1 <= in_a;
      r_t1 <= w_t;
      r_a2 <= r_a1;
      r_p2 <= w_p;
      r_r3 <= w_r;
    end
  end

`ifdef MONT_REDUCE_PIPE_CANON_EN
  localparam logic signed [WIDTH-1:0] Q_R = WIDTH'(Q);
  logic signed [WIDTH-1:0] r_r4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_r4 <= '0;
    end else if (en) begin
      r_r4 <= r_r3[WIDTH-1] ? r_r3 + Q_R : r_r3;
    end
  end

  assign out_r = r_r4;
`else
  assign out_r = r_r3;
`endif

endmodule

// File: rtl/mont_reduce_pipe.sv
// Multi-lane pipelined Montgomery reducer with valid/ready handshake and tag pass-through.
// Macro MONT_REDUCE_PIPE_CANON_EN lengthens the pipeline to 4 stages with output in [0, Q).
module mont_reduce_pipe
  import kyber_pkg::*;
#(
  parameter int WIDTH = KYBER_W,
  parameter int Q     = KYBER_Q,
  parameter int QINV  = KYBER_QINV,
  parameter int LANES = 2,
  parameter int TAG_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*2*WIDTH-1:0]   in_data,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*WIDTH-1:0]     out_data,
  output logic [TAG_W-1:0]           out_tag
);

  localparam int STAGES = MONT_STAGES;

  logic [STAGES-1:0] r_vld;
  logic [TAG_W-1:0]  r_tag [STAGES];
  logic              w_en;

  // One global enable: the whole pipe advances or the whole pipe holds.
  assign w_en      = !out_valid || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_vld[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < STAGES; i++) r_tag[i] <= '0;
    end else if (w_en) begin
      r_vld    <= {r_vld[STAGES-2:0], in_valid};
      r_tag[0] <= in_tag;
      for (int i = 1; i < STAGES; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mont_reduce_lane #(
      .WIDTH (WIDTH),
      .Q     (Q),
      .QINV  (QINV)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (w_en),
      .in_a  (in_data[g*2*WIDTH +: 2*WIDTH]),
      .out_r (out_data[g*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_mont_reduce_pipe.sv
// Self-checking bench for mont_reduce_pipe: vector table, streaming, back-pressure,
// mid-stream reset and random handshake traffic against an arithmetic reference model.
module tb_mont_reduce_pipe;
  import kyber_pkg::*;

  localparam int     W     = 16;
  localparam int     LANES = 2;
  localparam int     TAG_W = 8;
  localparam longint QL    = 3329;
  localparam longint QINVL = -3327;
  localparam longint HALF  = QL * 32768;
  localparam int unsigned SPAN = 218169344;
`ifdef MONT_REDUCE_PIPE_CANON_EN
  localparam int LAT   = 4;
  localparam bit CANON = 1'b1;
`else
  localparam int LAT   = 3;
  localparam bit CANON = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [LANES*2*W-1:0]     in_data = '0;
  logic [TAG_W-1:0]         in_tag = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [LANES*W-1:0]       out_data;
  logic [TAG_W-1:0]         out_tag;

  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    longint           a0;
    longint           a1;
    logic [TAG_W-1:0] tag;
  } beat_t;

  typedef struct {
    longint           a0;
    longint           a1;
    logic [TAG_W-1:0] tag;
    longint           e0;
    longint           e1;
  } vec_t;

  beat_t exp_q[$];
  beat_t mon_b;

  always #5 clk = ~clk;

  mont_reduce_pipe #(
    .WIDTH (W),
    .Q     (3329),
    .QINV  (-3327),
    .LANES (LANES),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: the reduction formula evaluated with wide integer arithmetic.
  function automatic longint model_r(input longint a);
    longint t, d, r;
    t = ((a & 64'hFFFF) * QINVL) & 64'hFFFF;
    if (t >= 32768) t -= 65536;
    d = a - t * QL;
    r = d >>> W;
    if (CANON && r < 0) r += QL;
    return r;
  endfunction

  function automatic longint canon_exp(input longint e);
    return (CANON && e < 0) ? e + QL : e;
  endfunction

  function automatic bit prop_ok(input longint r, input longint a);
    bit in_rng;
    in_rng = CANON ? (r >= 0 && r < QL) : (r > -QL && r < QL);
    return in_rng && (((r * 65536 - a) % QL) == 0);
  endfunction

  function automatic logic [LANES*2*W-1:0] pack(input longint a0, input longint a1);
    logic [2*W-1:0] x0, x1;
    x0 = a0[2*W-1:0];
    x1 = a1[2*W-1:0];
    return {x1, x0};
  endfunction

  function automatic longint lane(input int i);
    coef_t c;
    c = out_data[i*W +: W];
    return longint'(c);
  endfunction

  function automatic longint rand_a();
    case ($urandom_range(15))
      0:       return -HALF;
      1:       return HALF - 1;
      2:       return 0;
      3:       return -1;
      default: return longint'($urandom_range(SPAN - 1)) - HALF;
    endcase
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.a0  = rand_a();
    b.a1  = rand_a();
    b.tag = TAG_W'($urandom);
    return b;
  endfunction

  // Scoreboard: each output handshake must match the oldest accepted beat.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("s_unexpected_beat", 1, 0);
      end else begin
        mon_b = exp_q.pop_front();
        check("s_lane0", lane(0), model_r(mon_b.a0));
        check("s_lane1", lane(1), model_r(mon_b.a1));
        check("s_tag", longint'(out_tag), longint'(mon_b.tag));
        check("s_range_congruence", longint'(prop_ok(lane(0), mon_b.a0) && prop_ok(lane(1), mon_b.a1)), 1);
      end
    end
  end

  task automatic run_stream(input int nbeats, input int vpct, input int rpct, output int cyc);
    int    sent;
    bit    pend;
    beat_t cur;
    sent = 0;
    cyc  = 0;
    pend = 1'b0;
    cur  = rand_beat();
    mon_en = 1'b1;
    while ((sent < nbeats || exp_q.size() != 0) && cyc < 60000) begin
      @(posedge clk); #1;
      if (!pend && sent < nbeats && $urandom_range(99) < vpct) begin
        cur  = rand_beat();
        pend = 1'b1;
      end
      in_valid  = pend;
      in_data   = pack(cur.a0, cur.a1);
      in_tag    = cur.tag;
      out_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(cur);
        pend = 1'b0;
        sent++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    check("stream_sent", sent, nbeats);
    check("stream_drained", exp_q.size(), 0);
    mon_en = 1'b0;
  endtask

  task automatic run_backpressure();
    beat_t                bp[$];
    int                   nb;
    int                   cyc;
    logic [LANES*W-1:0]   snap_d;
    logic [TAG_W-1:0]     snap_t;
    for (int i = 0; i < LAT + 2; i++) bp.push_back(rand_beat());
    mon_en = 1'b1;
    nb = 0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = pack(bp[nb].a0, bp[nb].a1);
      in_tag    = bp[nb].tag;
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(bp[nb]);
        nb++;
      end
    end
    check("bp_accepted_before_stall", nb, LAT);
    check("bp_full_out_valid", longint'(out_valid), 1);
    snap_d = out_data;
    snap_t = out_tag;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_hold_data", longint'(out_data), longint'(snap_d));
      check("bp_hold_tag", longint'(out_tag), longint'(snap_t));
      check("bp_in_ready_low", longint'(in_ready), 0);
    end
    cyc = 0;
    while ((nb < bp.size() || exp_q.size() != 0) && cyc < 50) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (nb < bp.size()) begin
        in_valid = 1'b1;
        in_data  = pack(bp[nb].a0, bp[nb].a1);
        in_tag   = bp[nb].tag;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(bp[nb]);
        nb++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    check("bp_all_sent", nb, LAT + 2);
    check("bp_all_out", exp_q.size(), 0);
    mon_en = 1'b0;
  endtask

  task automatic run_reset_mid();
    bit stale;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = pack(longint'(k + 1) * 65536, -longint'(k + 1) * 65536);
      in_tag   = TAG_W'(8'hA0 + k);
      @(negedge clk);
      check("rst_pre_accept", longint'(in_ready), 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", longint'(out_valid), 0);
    check("rst_mid_out_data", longint'(out_data), 0);
    check("rst_mid_out_tag", longint'(out_tag), 0);
    check("rst_mid_in_ready", longint'(in_ready), 1);
    stale = 1'b0;
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("rst_no_stale_beat", longint'(stale), 0);
  endtask

  initial begin
    vec_t vt[6];
    int   cyc;
    vt[0] = '{a0: 1,          a1: 327680,     tag: 8'h11, e0: 169,  e1: 5};
    vt[1] = '{a0: -65536,     a1: 0,          tag: 8'h22, e0: -1,   e1: 0};
    vt[2] = '{a0: 0,          a1: -65536,     tag: 8'h33, e0: 0,    e1: -1};
    vt[3] = '{a0: 196608,     a1: -458752,    tag: 8'h44, e0: 3,    e1: -7};
    vt[4] = '{a0: -109084672, a1: 109051904,  tag: 8'h55, e0: 0,    e1: 1664};
    vt[5] = '{a0: 2,          a1: 65537,      tag: 8'h66, e0: 338,  e1: 170};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_data", longint'(out_data), 0);
    check("reset_out_tag", longint'(out_tag), 0);
    check("reset_in_ready", longint'(in_ready), 1);

    foreach (vt[i]) begin
      int n;
      bit acc;
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = pack(vt[i].a0, vt[i].a1);
      in_tag    = vt[i].tag;
      @(negedge clk);
      acc = in_ready;
      check($sformatf("vec%0d_accept", i), longint'(acc), 1);
      n = 0;
      do begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        n++;
        @(negedge clk);
      end while (!out_valid && n < 20);
      check($sformatf("vec%0d_latency", i), n, LAT);
      check($sformatf("vec%0d_lane0", i), lane(0), canon_exp(vt[i].e0));
      check($sformatf("vec%0d_lane1", i), lane(1), canon_exp(vt[i].e1));
      check($sformatf("vec%0d_tag", i), longint'(out_tag), longint'(vt[i].tag));
    end
    @(posedge clk); #1;
    repeat (2) @(negedge clk);

    run_stream(100, 100, 100, cyc);
    check("stream_one_per_cycle", longint'(cyc <= 100 + LAT + 1), 1);

    run_backpressure();
    run_reset_mid();

    run_stream(10000, 70, 70, cyc);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
